// File: rtl/ex_operand_stage_pkg.sv
// Shared encodings for the execute-stage operand path: ALUOp classes,
// ALU control codes and the funct3 values the ALU-control decode recognises.
package ex_operand_stage_pkg;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } aluop_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/ex_operand_stage_alu_ctrl_dec.sv
// Combinational ALU-control decode: ALUOp class plus funct3/funct7b5 to the
// 4-bit code consumed by the ALU. Unrecognised functs map to ALU_NOP.
module alu_ctrl_dec
  import ex_operand_stage_pkg::*;
(
  input  logic [1:0] aluOp_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] ctrl_o
);

  always_comb begin
    ctrl_o = ALU_NOP;
    case (aluop_e'(aluOp_i))
      ALUOP_MEM: ctrl_o = ALU_ADD;
      ALUOP_BR:  ctrl_o = ALU_SUB;
      ALUOP_R, ALUOP_I: begin
        case (funct3_i)
          // funct7b5 only selects sub for R-type; for I-type it is immediate bits
          F3_ADD:  ctrl_o = (aluOp_i == ALUOP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          F3_AND:  ctrl_o = ALU_AND;
          F3_OR:   ctrl_o = ALU_OR;
          F3_SLT:  ctrl_o = ALU_SLT;
          default: ctrl_o = ALU_NOP;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU-control decode, capture-time WB bypass and
// combinational MEM/WB forwarding onto the ALU operand and store-data outputs.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            idValid,
  input  logic [XLEN-1:0] idRs1Data,
  input  logic [XLEN-1:0] idRs2Data,
  input  logic [XLEN-1:0] idImm,
  input  logic [REGW-1:0] idRs1,
  input  logic [REGW-1:0] idRs2,
  input  logic [REGW-1:0] idRd,
  input  logic [1:0]      idALUOp,
  input  logic [2:0]      idFunct3,
  input  logic            idFunct7b5,
  input  logic            idALUSrc,
  input  logic            idRegWrite,
  input  logic            stall,
  input  logic            flush,
  input  logic            memRegWrite,
  input  logic [REGW-1:0] memRd,
  input  logic [XLEN-1:0] memALUOut,
  input  logic            wbRegWrite,
  input  logic [REGW-1:0] wbRd,
  input  logic [XLEN-1:0] wbData,
  output logic            exValid,
  output logic [XLEN-1:0] exIn0,
  output logic [XLEN-1:0] exIn1,
  output logic [3:0]      exALUCtrl,
  output logic [XLEN-1:0] exStoreData,
  output logic [REGW-1:0] exRd,
  output logic            exRegWrite
);

  logic            valid_q, valid_d;
  logic            regWrite_q, regWrite_d;
  logic            aluSrc_q, aluSrc_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic [REGW-1:0] rs1_q, rs1_d;
  logic [REGW-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] rs1Data_q, rs1Data_d;
  logic [XLEN-1:0] rs2Data_q, rs2Data_d;
  logic [XLEN-1:0] imm_q, imm_d;

  logic [3:0]      idCtrl;
  logic [XLEN-1:0] rs1Cap, rs2Cap;
  logic            loadBubble, capture;
  logic [XLEN-1:0] fwdRs1, fwdRs2;

  alu_ctrl_dec u_alu_ctrl_dec (
    .aluOp_i    (idALUOp),
    .funct3_i   (idFunct3),
    .funct7b5_i (idFunct7b5),
    .ctrl_o     (idCtrl)
  );

  // The register file is written at the same edge we capture, so pick up WB directly.
  assign rs1Cap = (wbRegWrite && wbRd != '0 && wbRd == idRs1) ? wbData : idRs1Data;
  assign rs2Cap = (wbRegWrite && wbRd != '0 && wbRd == idRs2) ? wbData : idRs2Data;

  assign loadBubble = flush || (!stall && !idValid);
  assign capture    = !flush && !stall && idValid;

  always_comb begin
    valid_d    = valid_q;
    regWrite_d = regWrite_q;
    aluSrc_d   = aluSrc_q;
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs1Data_d  = rs1Data_q;
    rs2Data_d  = rs2Data_q;
    imm_d      = imm_q;
    if (loadBubble) begin
      valid_d    = 1'b0;
      regWrite_d = 1'b0;
      aluSrc_d   = 1'b0;
      ctrl_d     = ALU_ADD;
      rd_d       = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rs1Data_d  = '0;
      rs2Data_d  = '0;
      imm_d      = '0;
    end else if (capture) begin
      valid_d    = 1'b1;
      regWrite_d = idRegWrite;
      aluSrc_d   = idALUSrc;
      ctrl_d     = idCtrl;
      rd_d       = idRd;
      rs1_d      = idRs1;
      rs2_d      = idRs2;
      rs1Data_d  = rs1Cap;
      rs2Data_d  = rs2Cap;
      imm_d      = idImm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regWrite_q <= 1'b0;
      aluSrc_q   <= 1'b0;
      ctrl_q     <= ALU_ADD;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1Data_q  <= '0;
      rs2Data_q  <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regWrite_q <= regWrite_d;
      aluSrc_q   <= aluSrc_d;
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1Data_q  <= rs1Data_d;
      rs2Data_q  <= rs2Data_d;
      imm_q      <= imm_d;
    end
  end

  // MEM is younger than WB, so it wins when both target the same register.
  assign fwdRs1 = (memRegWrite && memRd != '0 && memRd == rs1_q) ? memALUOut :
                  (wbRegWrite  && wbRd  != '0 && wbRd  == rs1_q) ? wbData : rs1Data_q;
  assign fwdRs2 = (memRegWrite && memRd != '0 && memRd == rs2_q) ? memALUOut :
                  (wbRegWrite  && wbRd  != '0 && wbRd  == rs2_q) ? wbData : rs2Data_q;

  assign exValid     = valid_q;
  assign exIn0       = fwdRs1;
  assign exIn1       = aluSrc_q ? imm_q : fwdRs2;
  assign exStoreData = fwdRs2;
  assign exALUCtrl   = ctrl_q;
  assign exRd        = rd_q;
  assign exRegWrite  = regWrite_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: a slot-level reference model checked every
// negative edge, plus directed scenarios with hand-computed literal results.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idValid, idFunct7b5, idALUSrc, idRegWrite, stall, flush;
  logic [31:0] idRs1Data, idRs2Data, idImm, memALUOut, wbData;
  logic [4:0]  idRs1, idRs2, idRd, memRd, wbRd;
  logic [1:0]  idALUOp;
  logic [2:0]  idFunct3;
  logic        memRegWrite, wbRegWrite;
  logic        exValid, exRegWrite;
  logic [31:0] exIn0, exIn1, exStoreData;
  logic [3:0]  exALUCtrl;
  logic [4:0]  exRd;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .idValid(idValid),
    .idRs1Data(idRs1Data), .idRs2Data(idRs2Data), .idImm(idImm),
    .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd),
    .idALUOp(idALUOp), .idFunct3(idFunct3), .idFunct7b5(idFunct7b5),
    .idALUSrc(idALUSrc), .idRegWrite(idRegWrite),
    .stall(stall), .flush(flush),
    .memRegWrite(memRegWrite), .memRd(memRd), .memALUOut(memALUOut),
    .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData),
    .exValid(exValid), .exIn0(exIn0), .exIn1(exIn1), .exALUCtrl(exALUCtrl),
    .exStoreData(exStoreData), .exRd(exRd), .exRegWrite(exRegWrite)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    bit          valid;
    bit          rw;
    bit          src;
    logic [3:0]  ctrl;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] d1, d2, imm;
  } slot_t;

  slot_t m;
  localparam logic [3:0] F3TAB [8] = '{4'h2, 4'hF, 4'h7, 4'hF, 4'hF, 4'hF, 4'h1, 4'h0};

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    logic [3:0] r;
    if (op == 2'd0) return 4'h2;
    if (op == 2'd1) return 4'h6;
    r = F3TAB[f3];
    if (op == 2'd2 && f3 == 3'd0 && f7) r = 4'h6;
    return r;
  endfunction

  function automatic slot_t bubble();
    slot_t b;
    b.valid = 0; b.rw = 0; b.src = 0; b.ctrl = 4'h2;
    b.rd = 0; b.rs1 = 0; b.rs2 = 0; b.d1 = 0; b.d2 = 0; b.imm = 0;
    return b;
  endfunction

  function automatic logic [31:0] regval(input logic [4:0] idx, input logic [31:0] held,
                                         input bit mem_ok);
    if (idx == 0) return held;
    if (mem_ok && memRegWrite && memRd == idx) return memALUOut;
    if (wbRegWrite && wbRd == idx) return wbData;
    return held;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m = bubble();
    else if (flush) m = bubble();
    else if (stall) m = m;
    else if (!idValid) m = bubble();
    else begin
      m.valid = 1; m.rw = idRegWrite; m.src = idALUSrc;
      m.ctrl = ref_ctrl(idALUOp, idFunct3, idFunct7b5);
      m.rd = idRd; m.rs1 = idRs1; m.rs2 = idRs2; m.imm = idImm;
      m.d1 = regval(idRs1, idRs1Data, 0);
      m.d2 = regval(idRs2, idRs2Data, 0);
    end
    armed = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      logic [31:0] o2;
      o2 = regval(m.rs2, m.d2, 1);
      chk("model exValid", {31'd0, exValid}, {31'd0, m.valid});
      chk("model exRegWrite", {31'd0, exRegWrite}, {31'd0, m.rw & m.valid});
      chk("model exRd", {27'd0, exRd}, {27'd0, m.rd});
      chk("model exALUCtrl", {28'd0, exALUCtrl}, {28'd0, m.ctrl});
      chk("model exIn0", exIn0, regval(m.rs1, m.d1, 1));
      chk("model exStoreData", exStoreData, o2);
      chk("model exIn1", exIn1, m.src ? m.imm : o2);
    end
  end

  task automatic set_idle();
    idValid = 0; idRs1Data = 0; idRs2Data = 0; idImm = 0;
    idRs1 = 0; idRs2 = 0; idRd = 0; idALUOp = 0; idFunct3 = 0; idFunct7b5 = 0;
    idALUSrc = 0; idRegWrite = 0; stall = 0; flush = 0;
    memRegWrite = 0; memRd = 0; memALUOut = 0; wbRegWrite = 0; wbRd = 0; wbData = 0;
  endtask

  task automatic id_instr(input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [4:0] rd, input logic [31:0] imm,
                          input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic src, input logic rw);
    idValid = 1; idRs1 = rs1; idRs1Data = d1; idRs2 = rs2; idRs2Data = d2;
    idRd = rd; idImm = imm; idALUOp = op; idFunct3 = f3; idFunct7b5 = f7;
    idALUSrc = src; idRegWrite = rw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset exValid", {31'd0, exValid}, 32'd0);
    chk("reset exALUCtrl", {28'd0, exALUCtrl}, 32'h2);
    chk("reset exIn0", exIn0, 32'd0);
    chk("reset exRd", {27'd0, exRd}, 32'd0);

    // R-type sub: x5 - x3
    id_instr(5, 32'd5, 3, 32'd3, 1, 0, 2'b10, 3'b000, 1, 0, 1);
    step(); set_idle(); @(negedge clk);
    chk("rtype ctrl", {28'd0, exALUCtrl}, 32'h6);
    chk("rtype in0", exIn0, 32'd5);
    chk("rtype in1", exIn1, 32'd3);
    chk("rtype regwrite", {31'd0, exRegWrite}, 32'd1);

    // funct3 sweep for R- and I-type, checked by the model
    for (int op = 2; op < 4; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int f7 = 0; f7 < 2; f7++) begin
          id_instr(5'(f3 + 1), 32'(f3), 5'(f3 + 2), 32'(f7), 2, 0, 2'(op), 3'(f3), 1'(f7), 0, 1);
          step();
        end
    set_idle();
    id_instr(1, 0, 2, 0, 3, 0, 2'b10, 3'b001, 0, 0, 1);
    step(); set_idle(); @(negedge clk);
    chk("rtype f3=001 nop", {28'd0, exALUCtrl}, 32'hF);
    id_instr(1, 0, 2, 0, 3, 0, 2'b11, 3'b000, 1, 0, 1);
    step(); set_idle(); @(negedge clk);
    chk("itype f7 ignored", {28'd0, exALUCtrl}, 32'h2);

    // MEM over WB priority, then no match with index 0
    id_instr(7, 32'h11, 0, 0, 2, 0, 2'b10, 3'b000, 0, 0, 1);
    step(); set_idle();
    memRegWrite = 1; memRd = 7; memALUOut = 32'hAA;
    wbRegWrite = 1; wbRd = 7; wbData = 32'hBB;
    @(negedge clk);
    chk("mem priority in0", exIn0, 32'hAA);
    memRd = 0; wbRd = 0; wbData = 32'h55;
    #1 chk("rd0 no forward in0", exIn0, 32'h11);

    // Capture-time WB bypass on rs2
    @(negedge clk); set_idle();
    id_instr(0, 0, 4, 32'h9999, 3, 0, 2'b10, 3'b000, 0, 0, 1);
    wbRegWrite = 1; wbRd = 4; wbData = 32'h1234;
    step(); set_idle(); @(negedge clk);
    chk("bypass in1", exIn1, 32'h1234);
    chk("bypass store", exStoreData, 32'h1234);

    // Stall two cycles, then flush+stall
    id_instr(1, 32'h100, 2, 32'h200, 5, 0, 2'b10, 3'b000, 0, 0, 1);
    step();
    id_instr(8, 32'h888, 9, 32'h999, 6, 0, 2'b10, 3'b111, 0, 0, 1);
    stall = 1;
    step(); @(negedge clk);
    chk("stall1 in0", exIn0, 32'h100);
    step(); @(negedge clk);
    chk("stall2 in1", exIn1, 32'h200);
    chk("stall2 rd", {27'd0, exRd}, 32'd5);
    flush = 1;
    step(); set_idle(); @(negedge clk);
    chk("flush valid", {31'd0, exValid}, 32'd0);
    chk("flush regwrite", {31'd0, exRegWrite}, 32'd0);
    chk("flush ctrl", {28'd0, exALUCtrl}, 32'h2);

    // I-type OR with immediate while MEM forwards rs2
    id_instr(0, 0, 9, 32'h77, 4, 32'hFFFF_FFF0, 2'b11, 3'b110, 0, 1, 1);
    step(); set_idle();
    memRegWrite = 1; memRd = 9; memALUOut = 32'hCAFE;
    @(negedge clk);
    chk("imm in1", exIn1, 32'hFFFF_FFF0);
    chk("imm store fwd", exStoreData, 32'hCAFE);
    chk("imm ctrl", {28'd0, exALUCtrl}, 32'h1);

    // Asynchronous reset during a stall
    set_idle();
    id_instr(3, 32'h33, 0, 0, 7, 0, 2'b10, 3'b000, 0, 0, 1);
    step(); set_idle(); stall = 1;
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async rst valid", {31'd0, exValid}, 32'd0);
    chk("async rst rd", {27'd0, exRd}, 32'd0);
    chk("async rst in0", exIn0, 32'd0);
    chk("async rst regwrite", {31'd0, exRegWrite}, 32'd0);
    step();
    rst = 0; stall = 0;
    step(); step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
